// File: rtl/sp_ram_req_ctrl.sv
// Single-port SRAM front-end: byte-enable expansion, credit-gated request accept, in-order read response FIFO.
// Read data appears 2 cycles after accept; REQ_READY closes once RSP_DEPTH reads are owed, reopens in a popping cycle.
module sp_ram_req_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic                    REQ_VALID,
   output logic                    REQ_READY,
   input  logic                    REQ_WE,
   input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
   input  logic [DATA_WIDTH-1:0]   REQ_WDATA,
   input  logic [DATA_WIDTH/8-1:0] REQ_BE,
   output logic                    RSP_VALID,
   input  logic                    RSP_READY,
   output logic [DATA_WIDTH-1:0]   RSP_RDATA,
   output logic [ADDR_WIDTH-1:0]   A,
   output logic [DATA_WIDTH-1:0]   DI,
   output logic [DATA_WIDTH-1:0]   BW,
   output logic                    CE,
   output logic                    RDWEN,
   input  logic [DATA_WIDTH-1:0]   DO
);
   localparam int BE_W = DATA_WIDTH / 8;
   localparam int PW   = $clog2(RSP_DEPTH);
   localparam int CW   = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic                  rd_inflight_q, rd_inflight_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
   logic [CW-1:0]         occ;
   logic                  acc, pop, push;

   // A read in flight already owns a FIFO slot, so it counts as a credit in use.
   assign occ       = cnt_q + CW'(rd_inflight_q);
   assign RSP_VALID = (cnt_q != '0);
   assign RSP_RDATA = mem_q[rd_ptr_q];
   assign pop       = RSP_VALID & RSP_READY;
   assign push      = rd_inflight_q;
   assign REQ_READY = RSTN & ((occ - CW'(pop)) < DEPTH_C);
   assign acc       = REQ_VALID & REQ_READY;

   assign CE    = acc;
   assign A     = REQ_ADDR;
   assign DI    = REQ_WDATA;
   assign RDWEN = REQ_WE;

   always_comb begin
      BW = '0;
      for (int i = 0; i < BE_W; i++) begin
         BW[8*i +: 8] = {8{REQ_BE[i]}};
      end
   end

   always_comb begin
      rd_inflight_d = acc & ~REQ_WE;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      cnt_d         = cnt_q;
      mem_d         = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = DO;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rd_inflight_q <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         mem_q         <= '{default: '0};
      end else begin
         rd_inflight_q <= rd_inflight_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cnt_q         <= cnt_d;
         mem_q         <= mem_d;
      end
   end
endmodule

// File: doc/sp_ram_req_ctrl.md
# sp_ram_req_ctrl

Request/response front-end for the single-port SRAM macro (`sp_ram_model`). It accepts read/write requests over a valid/ready handshake and expands byte enables into the macro's bit-write mask. It drives the macro's A/DI/BW/CE/RDWEN pins and captures the macro's registered read data into a small response FIFO with its own valid/ready handshake. Credit-based flow control guarantees that no read data is ever dropped, even under response backpressure.

## Interface
- `ADDR_WIDTH`, 10, word address width; must match the macro.
- `DATA_WIDTH`, 32, word width; must be a multiple of 8.
- `RSP_DEPTH`, 2, response FIFO entries; power of two, ≥2.
- `CLK`  in  1  clock; all logic is on the rising edge.
- `RSTN`  in  1  asynchronous active-low reset.
- `REQ_VALID`  in  1  request valid.
- `REQ_READY`  out  1  request accepted when `REQ_VALID & REQ_READY`.
- `REQ_WE`  in  1  1 = write, 0 = read.
- `REQ_ADDR`  in  ADDR_WIDTH  word address.
- `REQ_WDATA`  in  DATA_WIDTH  write data.
- `REQ_BE`  in  DATA_WIDTH/8  byte enables; ignored on reads.
- `RSP_VALID`  out  1  read data valid.
- `RSP_READY`  in  1  consumer accepts the response.
- `RSP_RDATA`  out  DATA_WIDTH  read data, in request order.
- `A`  out  ADDR_WIDTH  to macro.
- `DI`  out  DATA_WIDTH  to macro.
- `BW`  out  DATA_WIDTH  to macro; bit mask.
- `CE`  out  1  to macro.
- `RDWEN`  out  1  to macro; 1 = write.
- `DO`  in  DATA_WIDTH  from macro; registered one cycle after a read.

## Operation
- Accept: `acc = REQ_VALID & REQ_READY`.
- Macro pins are combinational from the request: `CE = acc`, `A = REQ_ADDR`, `DI = REQ_WDATA`, `RDWEN = REQ_WE`.
- `BW`: byte i (bits 8i+7..8i) = `{8{REQ_BE[i]}}`.
- Write: the macro updates on the accept edge. No response is produced. `REQ_BE = 0` still issues `CE` and leaves memory unchanged.
- Read: `rd_inflight` is set on the accept edge. In the following cycle `DO` is valid and is pushed into the FIFO at the end of that cycle.
- Credit counter: `occ = fifo_count + rd_inflight`, range 0..RSP_DEPTH.
- `pop = RSP_VALID & RSP_READY`.
- `REQ_READY = RSTN & (occ - pop < RSP_DEPTH)`. This holds for writes too: a single rule, independent of `REQ_WE`.
- `REQ_READY` is combinational from `RSP_READY`. It must not depend on `REQ_VALID`.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - `RSP_RDATA` is the head entry; `RSP_VALID = fifo_count != 0`.
  - Simultaneous push and pop leaves the count unchanged and both pointers advance.
  - Push to a full FIFO is impossible by the credit rule; the bench asserts this.
- Ordering: responses are returned strictly in read-accept order. Writes interleaved between reads do not reorder them.
- Read-after-write to the same address on consecutive accepted cycles returns the new data, because the macro wrote on the earlier edge.

## Timing
- Reset (`RSTN` low, asynchronous):
  - `fifo_count = 0`, pointers = 0, `rd_inflight = 0`.
  - `RSP_VALID = 0`, `REQ_READY = 0`, `CE = 0`.
  - `RSP_RDATA` is don't-care; the bench checks it only when `RSP_VALID` is high.
- First cycle after deassertion: `REQ_READY = 1`.
- Reset mid-operation: any in-flight read and all queued responses are discarded and never presented. Macro contents are unaffected.
- Read accepted in cycle t:
  - `RSP_VALID` rises in cycle t+2 (latency 2).
  - With `RSP_READY` held high, back-to-back reads sustain 1 response/cycle for `RSP_DEPTH ≥ 2`.
- Backpressure with `RSP_READY` low: at most `RSP_DEPTH` reads are outstanding, after which `REQ_READY = 0`. One pop in a cycle re-enables `REQ_READY` in that same cycle.
- `RSP_VALID` and `RSP_RDATA` are stable while `RSP_VALID & !RSP_READY`.

## Test plan
- Reset, write-then-read:
  - Stimulus: reset; write addr 0x005 data 0xDEADBEEF, BE=0xF; read 0x005 with `RSP_READY=1`.
  - Required: `RSP_VALID` at read cycle+2 with data 0xDEADBEEF; `CE` high exactly on the 2 accept cycles.
- Byte enables:
  - Stimulus: write 0x11223344 (BE=0xF), then 0xAABBCCDD with BE=0x5, read back.
  - Required: `BW = 0x00FF00FF` on the second write; read returns 0x11BB33DD.
- Streaming:
  - Stimulus: 16 back-to-back reads of addrs 0..15, preloaded with data = addr×3, `RSP_READY=1`.
  - Required: `REQ_READY` never drops; 16 consecutive responses 0,3,…,45 starting 2 cycles after the first accept.
- Backpressure:
  - Stimulus: `RSP_READY=0`, issue 4 reads.
  - Required: `REQ_READY` falls after 2 accepts; `RSP_RDATA` holds; release `RSP_READY` and the remaining reads complete in order; no loss or duplication.
- Mixed and wrap-around:
  - Stimulus: random R/W mix with random `RSP_READY` for 10k cycles against a reference memory.
  - Required: all read data matches; FIFO pointers wrap repeatedly; `occ` never exceeds `RSP_DEPTH`.
- Reset mid-flight:
  - Stimulus: assert `RSTN` low the cycle after a read accept with 2 responses queued.
  - Required: `RSP_VALID=0` immediately and stays 0 after release until new reads; memory contents preserved.
